// File: rtl/mem_pkg.sv
// Shared definitions for the memory-port arbiter: tag width, MESI and
// transaction encodings, and the arbiter state enum.
package mem_pkg;

  localparam int TAG_W = 8;

  typedef logic [TAG_W-1:0] tag_t;

  localparam tag_t MESI_I = 8'd0;
  localparam tag_t MESI_S = 8'd1;
  localparam tag_t MESI_E = 8'd2;
  localparam tag_t MESI_M = 8'd3;

  localparam tag_t TRSC_NONE = 8'd0;
  localparam tag_t TRSC_RD   = 8'd1;
  localparam tag_t TRSC_RDX  = 8'd2;
  localparam tag_t TRSC_WR   = 8'd3;
  localparam tag_t TRSC_UPG  = 8'd4;

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational round-robin picker: first set bit of req scanning from ptr
// upward, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int j;

  // Scan from the far end back toward ptr so the closest candidate wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arb.sv
// N-to-1 round-robin arbiter for the rqst/trsc/addr/resp/mesi/lock memory
// port, with lock-held grants and a drain phase between grantees.
//
// state | meaning
// IDLE  | no grant; pick next requester from ptr
// BUSY  | requester g owns the port; registered forwarding both ways
// DRAIN | grant dropped; wait for downstream resp to return to 0
module mem_arb
  import mem_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               s_mem_lock,
  input  logic [N-1:0][TAG_W-1:0]    s_mem_rqst,
  input  logic [N-1:0][TAG_W-1:0]    s_mem_trsc,
  input  logic [N-1:0][AW-1:0]       s_mem_addr,
  output logic [N-1:0][TAG_W-1:0]    s_mem_resp,
  output logic [N-1:0][TAG_W-1:0]    s_mem_mesi,
  output logic                       m_mem_lock,
  output logic [TAG_W-1:0]           m_mem_rqst,
  output logic [TAG_W-1:0]           m_mem_trsc,
  output logic [AW-1:0]              m_mem_addr,
  input  logic [TAG_W-1:0]           m_mem_resp,
  input  logic [TAG_W-1:0]           m_mem_mesi,
  output logic [N-1:0]               grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [IW-1:0] g;
  logic [IW-1:0] ptr;
  logic [N-1:0]  req;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          release_g;

  always_comb begin
    req = '0;
    for (int i = 0; i < N; i++) req[i] = |s_mem_rqst[i];
  end

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // An abort (rqst dropped before completion) releases exactly like completion.
  assign release_g = (s_mem_rqst[g] == '0) && !s_mem_lock[g];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      g          <= '0;
      ptr        <= '0;
      grant      <= '0;
      m_mem_lock <= 1'b0;
      m_mem_rqst <= '0;
      m_mem_trsc <= '0;
      m_mem_addr <= '0;
      s_mem_resp <= '0;
      s_mem_mesi <= '0;
    end else begin
      case (state)
        IDLE: begin
          m_mem_lock <= 1'b0;
          m_mem_rqst <= '0;
          m_mem_trsc <= '0;
          m_mem_addr <= '0;
          s_mem_resp <= '0;
          s_mem_mesi <= '0;
          grant      <= '0;
          if (pick_valid) begin
            g     <= pick_idx;
            grant <= N'(1) << pick_idx;
            ptr   <= (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          s_mem_resp <= '0;
          s_mem_mesi <= '0;
          if (release_g) begin
            m_mem_lock <= 1'b0;
            m_mem_rqst <= '0;
            m_mem_trsc <= '0;
            m_mem_addr <= '0;
            grant      <= '0;
            state      <= DRAIN;
          end else begin
            m_mem_lock    <= s_mem_lock[g];
            m_mem_rqst    <= s_mem_rqst[g];
            m_mem_trsc    <= s_mem_trsc[g];
            m_mem_addr    <= s_mem_addr[g];
            s_mem_resp[g] <= m_mem_resp;
            s_mem_mesi[g] <= m_mem_mesi;
          end
        end
        DRAIN: begin
          m_mem_lock <= 1'b0;
          m_mem_rqst <= '0;
          m_mem_trsc <= '0;
          m_mem_addr <= '0;
          s_mem_resp <= '0;
          s_mem_mesi <= '0;
          grant      <= '0;
          if (m_mem_resp == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scenario bench for mem_arb: expected grant order is queued as stimulus is
// driven and popped by a monitor whenever a new grant appears.
module tb_mem_arb;
  import mem_pkg::*;

  localparam int N  = 4;
  localparam int AW = 64;

  logic                clk;
  logic                rst;
  logic [N-1:0]        lock;
  logic [N-1:0][7:0]   rq;
  logic [N-1:0][7:0]   trsc;
  logic [N-1:0][AW-1:0] addr;
  logic [N-1:0][7:0]   resp_s;
  logic [N-1:0][7:0]   mesi_s;
  logic                m_lock;
  logic [7:0]          m_rqst;
  logic [7:0]          m_trsc;
  logic [AW-1:0]       m_addr;
  logic [7:0]          m_resp;
  logic [7:0]          m_mesi;
  logic [N-1:0]        grant;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];

  logic [N-1:0] auto_drop;
  int           drop_delay;
  bit           resp_en;
  int           lock_bad;
  int           early0;

  mem_arb #(.N(N), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_mem_lock (lock),
    .s_mem_rqst (rq),
    .s_mem_trsc (trsc),
    .s_mem_addr (addr),
    .s_mem_resp (resp_s),
    .s_mem_mesi (mesi_s),
    .m_mem_lock (m_lock),
    .m_mem_rqst (m_rqst),
    .m_mem_trsc (m_trsc),
    .m_mem_addr (m_addr),
    .m_mem_resp (m_resp),
    .m_mem_mesi (m_mesi),
    .grant      (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream slave: echoes the forwarded tag, keeps resp up drop_delay
  // extra cycles after rqst falls.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        m_resp = '0; m_mesi = '0; hold = 0;
      end else if (m_rqst != 0) begin
        m_resp = m_rqst; m_mesi = MESI_E; hold = drop_delay;
      end else if (hold != 0) begin
        hold--;
      end else begin
        m_resp = '0; m_mesi = '0;
      end
    end
  end

  // Requester agents: drop rqst once the response tag matches.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (auto_drop[i] && rq[i] != 0 && resp_s[i] == rq[i]) rq[i] = '0;
    end
  end

  // Grant-order scoreboard.
  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] exp_g;
    int e;
    prev_g = '0;
    forever begin
      @(posedge clk); #1;
      if (grant != 0 && prev_g == 0) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL grant_order: got grant %b, expected no grant", grant);
        end else begin
          e = exp_q.pop_front();
          exp_g = '0;
          exp_g[e] = 1'b1;
          if (grant !== exp_g) begin
            n_fail++;
            $display("FAIL grant_order: got grant %b, expected %b", grant, exp_g);
          end
        end
      end
      prev_g = grant;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget && dut.state != IDLE; c++) tick(1);
    n_tests++;
    if (dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL %s_idle: got state %0d, expected IDLE", name, dut.state);
    end
  endtask

  task automatic lock_cycle;
    tick(1);
    if (m_lock !== 1'b1) lock_bad++;
    if (grant[0]) early0++;
  endtask

  task automatic test_reset;
    do_reset;
    rst = 1'b1;
    tick(1);
    n_tests++;
    if (m_rqst !== 8'h00 || m_lock !== 1'b0 || m_trsc !== 8'h00 || m_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_m: got rqst %h lock %b trsc %h addr %h, expected all 0", m_rqst, m_lock, m_trsc, m_addr);
    end
    n_tests++;
    if (grant !== '0 || resp_s !== '0 || mesi_s !== '0) begin
      n_fail++;
      $display("FAIL reset_s: got grant %b resp %h mesi %h, expected all 0", grant, resp_s, mesi_s);
    end
    n_tests++;
    if (dut.state !== IDLE || dut.ptr !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got state %0d ptr %0d, expected IDLE 0", dut.state, dut.ptr);
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_single;
    bit saw_drain;
    auto_drop = '0; auto_drop[1] = 1'b1;
    rq[1] = 8'h05; addr[1] = 64'h1000; trsc[1] = TRSC_RD;
    exp_q.push_back(1);
    tick(1);
    n_tests++;
    if (grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_grant: got %b, expected 0010", grant);
    end
    tick(1);
    n_tests++;
    if (m_rqst !== 8'h05 || m_addr !== 64'h1000 || m_trsc !== TRSC_RD) begin
      n_fail++;
      $display("FAIL single_fwd: got rqst %h addr %h trsc %h, expected 05 1000 %h", m_rqst, m_addr, m_trsc, TRSC_RD);
    end
    n_tests++;
    if (resp_s[1] !== 8'h00) begin
      n_fail++;
      $display("FAIL single_early_resp: got %h, expected 00", resp_s[1]);
    end
    tick(1);
    n_tests++;
    if (resp_s[1] !== 8'h05 || mesi_s[1] !== MESI_E) begin
      n_fail++;
      $display("FAIL single_resp: got resp %h mesi %h, expected 05 %h", resp_s[1], mesi_s[1], MESI_E);
    end
    saw_drain = 1'b0;
    for (int c = 0; c < 10 && !(saw_drain && dut.state == IDLE); c++) begin
      tick(1);
      if (dut.state == DRAIN) saw_drain = 1'b1;
    end
    n_tests++;
    if (!saw_drain || dut.state !== IDLE || grant !== '0) begin
      n_fail++;
      $display("FAIL single_release: got drain %b state %0d grant %b, expected 1 IDLE 0000", saw_drain, dut.state, grant);
    end
  endtask

  task automatic test_contention;
    do_reset;
    auto_drop = '1;
    rq[0] = 8'h21; rq[2] = 8'h22; rq[3] = 8'h23;
    exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(3);
    for (int c = 0; c < 60 && rq != '0; c++) tick(1);
    n_tests++;
    if (rq !== '0) begin
      n_fail++;
      $display("FAIL contention_done: got pending rqst %h, expected all served", rq);
    end
    wait_idle("contention", 10);
    n_tests++;
    if (dut.ptr !== 2'd0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL contention_ptr: got ptr %0d queue %0d, expected 0 0", dut.ptr, exp_q.size());
    end
  endtask

  task automatic test_lock;
    auto_drop = '0; auto_drop[0] = 1'b1;
    lock_bad = 0; early0 = 0;
    rq[2] = 8'h11; lock[2] = 1'b1;
    exp_q.push_back(2);
    tick(1);
    n_tests++;
    if (grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_grant: got %b, expected 0100", grant);
    end
    rq[0] = 8'h31; addr[0] = 64'h2000;
    exp_q.push_back(0);
    lock_cycle();
    for (int c = 0; c < 10 && resp_s[2] != 8'h11; c++) lock_cycle();
    rq[2] = 8'h00;
    repeat (3) lock_cycle();
    n_tests++;
    if (grant !== 4'b0100 || m_rqst !== 8'h00) begin
      n_fail++;
      $display("FAIL lock_gap: got grant %b rqst %h, expected 0100 00", grant, m_rqst);
    end
    rq[2] = 8'h12;
    for (int c = 0; c < 10 && resp_s[2] != 8'h12; c++) lock_cycle();
    n_tests++;
    if (resp_s[2] !== 8'h12) begin
      n_fail++;
      $display("FAIL lock_second: got resp %h, expected 12", resp_s[2]);
    end
    n_tests++;
    if (lock_bad != 0 || early0 != 0) begin
      n_fail++;
      $display("FAIL lock_hold: got %0d lock drops %0d early grants, expected 0 0", lock_bad, early0);
    end
    rq[2] = 8'h00; lock[2] = 1'b0;
    for (int c = 0; c < 15 && !grant[0]; c++) tick(1);
    n_tests++;
    if (grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL lock_next: got grant %b, expected 0001", grant);
    end
    for (int c = 0; c < 15 && rq[0] != 0; c++) tick(1);
    wait_idle("lock", 10);
  endtask

  task automatic test_collision;
    int leak;
    bit fwd1;
    do_reset;
    drop_delay = 3;
    auto_drop = '0; auto_drop[0] = 1'b1; auto_drop[1] = 1'b1;
    rq[0] = 8'h07; rq[1] = 8'h07;
    exp_q.push_back(0); exp_q.push_back(1);
    leak = 0; fwd1 = 1'b0;
    for (int c = 0; c < 60 && rq[1] != 0; c++) begin
      tick(1);
      if (resp_s[1] == 8'h07 && !fwd1) leak++;
      if (grant[1] && m_rqst == 8'h07) fwd1 = 1'b1;
    end
    n_tests++;
    if (leak != 0 || !fwd1) begin
      n_fail++;
      $display("FAIL collision_leak: got %0d leaked cycles fwd %b, expected 0 1", leak, fwd1);
    end
    wait_idle("collision", 15);
    drop_delay = 0;
  endtask

  task automatic test_abort;
    resp_en = 1'b0;
    auto_drop = '0;
    rq[3] = 8'h33;
    exp_q.push_back(3);
    tick(1);
    n_tests++;
    if (grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_grant: got %b, expected 1000", grant);
    end
    tick(1);
    n_tests++;
    if (m_rqst !== 8'h33) begin
      n_fail++;
      $display("FAIL abort_fwd: got %h, expected 33", m_rqst);
    end
    rq[3] = 8'h00;
    tick(1);
    n_tests++;
    if (m_rqst !== 8'h00 || grant !== '0 || resp_s[3] !== 8'h00 || dut.state !== DRAIN) begin
      n_fail++;
      $display("FAIL abort_release: got rqst %h grant %b resp %h state %0d, expected 00 0000 00 DRAIN", m_rqst, grant, resp_s[3], dut.state);
    end
    resp_en = 1'b1;
    wait_idle("abort", 5);
  endtask

  task automatic test_reset_busy;
    resp_en = 1'b0;
    rq[1] = 8'h09;
    exp_q.push_back(1);
    for (int c = 0; c < 6 && m_rqst != 8'h09; c++) tick(1);
    n_tests++;
    if (m_rqst !== 8'h09) begin
      n_fail++;
      $display("FAIL rstbusy_fwd: got %h, expected 09", m_rqst);
    end
    rst = 1'b1; rq[1] = 8'h00;
    tick(1);
    n_tests++;
    if (m_rqst !== 8'h00 || m_lock !== 1'b0 || grant !== '0 || resp_s !== '0 || dut.state !== IDLE) begin
      n_fail++;
      $display("FAIL rstbusy_abort: got rqst %h lock %b grant %b resp %h state %0d, expected all 0 IDLE", m_rqst, m_lock, grant, resp_s, dut.state);
    end
    rst = 1'b0;
    tick(1);
    n_tests++;
    if (dut.ptr !== 2'd0) begin
      n_fail++;
      $display("FAIL rstbusy_ptr: got %0d, expected 0", dut.ptr);
    end
    resp_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    lock = '0; rq = '0; trsc = '0; addr = '0;
    m_resp = '0; m_mesi = '0;
    auto_drop = '0; drop_delay = 0; resp_en = 1'b1;
    test_reset;
    test_single;
    test_contention;
    test_lock;
    test_collision;
    test_abort;
    test_reset_busy;
    tick(2);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL grant_queue: got %0d unserved, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
